// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU: holds dispatched instructions until both
// operands are known, snoops ALU/LSB result broadcasts, and issues one ready entry per cycle.
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 4,
    parameter int OP_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 issue_valid,
    input  logic [OP_W-1:0]      issue_op,
    input  logic [31:0]          issue_pc,
    input  logic [31:0]          issue_imm,
    input  logic [ROB_IDX_W-1:0] issue_rd_rename,
    input  logic                 issue_qj_busy,
    input  logic                 issue_qk_busy,
    input  logic [ROB_IDX_W-1:0] issue_qj,
    input  logic [ROB_IDX_W-1:0] issue_qk,
    input  logic [31:0]          issue_vj,
    input  logic [31:0]          issue_vk,
    output logic                 rs_full,

    input  logic                 alu_bc_valid,
    input  logic [ROB_IDX_W-1:0] alu_bc_tag,
    input  logic [31:0]          alu_bc_value,
    input  logic                 lsb_bc_valid,
    input  logic [ROB_IDX_W-1:0] lsb_bc_tag,
    input  logic [31:0]          lsb_bc_value,

    output logic                 alu_enable,
    output logic [ROB_IDX_W-1:0] alu_rd_rename,
    output logic [31:0]          alu_pc,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_rs1_value,
    output logic [31:0]          alu_rs2_value,
    output logic [OP_W-1:0]      alu_op
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]   busy_reg;
    logic [RS_SIZE-1:0]   qj_busy_reg;
    logic [RS_SIZE-1:0]   qk_busy_reg;
    logic [OP_W-1:0]      op_reg  [RS_SIZE];
    logic [31:0]          pc_reg  [RS_SIZE];
    logic [31:0]          imm_reg [RS_SIZE];
    logic [31:0]          vj_reg  [RS_SIZE];
    logic [31:0]          vk_reg  [RS_SIZE];
    logic [ROB_IDX_W-1:0] rd_reg  [RS_SIZE];
    logic [ROB_IDX_W-1:0] qj_reg  [RS_SIZE];
    logic [ROB_IDX_W-1:0] qk_reg  [RS_SIZE];

    logic [RS_SIZE-1:0]   ready;
    logic [RS_SIZE-1:0]   j_wake;
    logic [RS_SIZE-1:0]   k_wake;
    logic [31:0]          j_wake_value [RS_SIZE];
    logic [31:0]          k_wake_value [RS_SIZE];

    // Per-entry readiness and broadcast snooping; the ALU broadcast wins on a tag tie.
    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic j_alu_hit, j_lsb_hit, k_alu_hit, k_lsb_hit;
            assign ready[gi]     = busy_reg[gi] & ~qj_busy_reg[gi] & ~qk_busy_reg[gi];
            assign j_alu_hit     = alu_bc_valid && (alu_bc_tag == qj_reg[gi]);
            assign j_lsb_hit     = lsb_bc_valid && (lsb_bc_tag == qj_reg[gi]);
            assign k_alu_hit     = alu_bc_valid && (alu_bc_tag == qk_reg[gi]);
            assign k_lsb_hit     = lsb_bc_valid && (lsb_bc_tag == qk_reg[gi]);
            assign j_wake[gi]    = busy_reg[gi] && qj_busy_reg[gi] && (j_alu_hit || j_lsb_hit);
            assign k_wake[gi]    = busy_reg[gi] && qk_busy_reg[gi] && (k_alu_hit || k_lsb_hit);
            assign j_wake_value[gi] = j_alu_hit ? alu_bc_value : lsb_bc_value;
            assign k_wake_value[gi] = k_alu_hit ? alu_bc_value : lsb_bc_value;
        end
    endgenerate

    logic             issue_found;
    logic [IDX_W-1:0] issue_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    // Lowest-index priority: scan high to low so the last hit is the lowest index.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_reg[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    logic        in_qj_busy, in_qk_busy;
    logic [31:0] in_vj, in_vk;

    // Dispatch bypass: an operand produced in this very cycle is captured on the way in.
    always_comb begin
        in_qj_busy = issue_qj_busy;
        in_vj      = issue_vj;
        in_qk_busy = issue_qk_busy;
        in_vk      = issue_vk;
        if (issue_qj_busy) begin
            if (alu_bc_valid && (alu_bc_tag == issue_qj)) begin
                in_qj_busy = 1'b0;
                in_vj      = alu_bc_value;
            end else if (lsb_bc_valid && (lsb_bc_tag == issue_qj)) begin
                in_qj_busy = 1'b0;
                in_vj      = lsb_bc_value;
            end
        end
        if (issue_qk_busy) begin
            if (alu_bc_valid && (alu_bc_tag == issue_qk)) begin
                in_qk_busy = 1'b0;
                in_vk      = alu_bc_value;
            end else if (lsb_bc_valid && (lsb_bc_tag == issue_qk)) begin
                in_qk_busy = 1'b0;
                in_vk      = lsb_bc_value;
            end
        end
    end

    assign rs_full = &busy_reg;

    logic do_insert;
    assign do_insert = issue_valid && !rs_full && free_found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg    <= '0;
            qj_busy_reg <= '0;
            qk_busy_reg <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_reg[i]  <= '0;
                pc_reg[i]  <= '0;
                imm_reg[i] <= '0;
                vj_reg[i]  <= '0;
                vk_reg[i]  <= '0;
                rd_reg[i]  <= '0;
                qj_reg[i]  <= '0;
                qk_reg[i]  <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                busy_reg <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (do_insert && (free_idx == IDX_W'(i))) begin
                        busy_reg[i]    <= 1'b1;
                        op_reg[i]      <= issue_op;
                        pc_reg[i]      <= issue_pc;
                        imm_reg[i]     <= issue_imm;
                        rd_reg[i]      <= issue_rd_rename;
                        qj_busy_reg[i] <= in_qj_busy;
                        qj_reg[i]      <= issue_qj;
                        vj_reg[i]      <= in_vj;
                        qk_busy_reg[i] <= in_qk_busy;
                        qk_reg[i]      <= issue_qk;
                        vk_reg[i]      <= in_vk;
                    end else begin
                        if (issue_found && (issue_idx == IDX_W'(i)))
                            busy_reg[i] <= 1'b0;
                        if (j_wake[i]) begin
                            qj_busy_reg[i] <= 1'b0;
                            vj_reg[i]      <= j_wake_value[i];
                        end
                        if (k_wake[i]) begin
                            qk_busy_reg[i] <= 1'b0;
                            vk_reg[i]      <= k_wake_value[i];
                        end
                    end
                end
            end
        end
    end

    // ALU input bundle; everything but alu_enable holds when nothing issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_enable    <= 1'b0;
            alu_rd_rename <= '0;
            alu_pc        <= '0;
            alu_imm       <= '0;
            alu_rs1_value <= '0;
            alu_rs2_value <= '0;
            alu_op        <= '0;
        end else if (rdy) begin
            if (rollback || !issue_found) begin
                alu_enable <= 1'b0;
            end else begin
                alu_enable    <= 1'b1;
                alu_rd_rename <= rd_reg[issue_idx];
                alu_pc        <= pc_reg[issue_idx];
                alu_imm       <= imm_reg[issue_idx];
                alu_rs1_value <= vj_reg[issue_idx];
                alu_rs2_value <= vk_reg[issue_idx];
                alu_op        <= op_reg[issue_idx];
            end
        end
    end

endmodule
